// File: rtl/button_event_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, registered
// press/release strobes and a saturating hold detector.
module button_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_clean_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_flag
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic          sync1_q, sync_n_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          clean_n_q, clean_n_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hold_flag_q, hold_flag_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_q != HOLD_MAX)
      hold_d = hold_q + HW'(1);
    case (state_q)
      RELEASED: begin
        if (!sync_n_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync_n_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = '0;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (sync_n_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed keeps the hold count running.
        if (!sync_n_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    clean_n_d   = !(state_d == PRESSED || state_d == RELEASE_WAIT);
    hold_flag_d = !clean_n_d && (hold_d == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync_n_q    <= 1'b1;
      state_q     <= RELEASED;
      cnt_q       <= '0;
      hold_q      <= '0;
      clean_n_q   <= 1'b1;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      hold_flag_q <= 1'b0;
    end else begin
      sync1_q     <= btn_n;
      sync_n_q    <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      clean_n_q   <= clean_n_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      hold_flag_q <= hold_flag_d;
    end
  end

  assign btn_clean_n   = clean_n_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign hold_flag     = hold_flag_q;

endmodule

// File: tb/tb_button_event_conditioner.sv
// Bench for button_event_conditioner: directed scenarios plus random bounce,
// compared every cycle against a run-length debounce reference model.
module tb_button_event_conditioner;

  localparam int D = 4;
  localparam int H = 16;

  logic clk, rst, btn_n;
  logic btn_clean_n, press_pulse, release_pulse, hold_flag;

  button_event_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .btn_clean_n(btn_clean_n), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .hold_flag(hold_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two-sample delay line, then the accepted level flips
  // once D consecutive samples disagree with it.
  logic m_s1, m_s2, m_lvl, m_press, m_rel;
  int   m_run, m_held;
  int   tick_no, n_press, n_rel;
  logic [3:0] ev_cnt;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1;
    m_press = 1'b0; m_rel = 1'b0; m_run = 0; m_held = 0;
  endtask

  task automatic tick();
    logic s;
    logic drv;
    drv = btn_n;
    @(posedge clk);
    #1;
    tick_no++;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = drv;
    m_press = 1'b0;
    m_rel = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D) begin
        m_lvl = s;
        m_run = 0;
        if (s == 1'b0) begin
          m_press = 1'b1;
          m_held = 0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    if (m_lvl == 1'b0 && !m_press && m_held < 1000) m_held++;
    chk("btn_clean_n", btn_clean_n, m_lvl);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("hold_flag", hold_flag, (m_lvl == 1'b0) && (m_held >= H));
    if (press_pulse) begin n_press++; ev_cnt = ev_cnt + 4'd1; end
    if (release_pulse) n_rel++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clean"}, btn_clean_n, 1'b1);
    chk({tag, "_press"}, press_pulse, 1'b0);
    chk({tag, "_rel"},   release_pulse, 1'b0);
    chk({tag, "_hold"},  hold_flag, 1'b0);
  endtask

  int first_press_tick;
  int p0, r0;

  initial begin
    rst = 1'b0;
    btn_n = 1'b1;
    tick_no = 0; n_press = 0; n_rel = 0; ev_cnt = 4'd0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    #5 rst = 1'b1;

    // Clean press: btn_n falls before edge 10, held 40 cycles
    ticks(9);
    btn_n = 1'b0;
    first_press_tick = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (press_pulse && first_press_tick < 0) first_press_tick = tick_no;
    end
    chk("press_edge", first_press_tick, 15);
    chk("press_count", n_press, 1);
    btn_n = 1'b1;
    ticks(12);
    chk("release_count", n_rel, 1);

    // Bounce reject: low 2, high 5, four times
    p0 = n_press;
    for (int r = 0; r < 4; r++) begin
      btn_n = 1'b0; ticks(2);
      btn_n = 1'b1; ticks(5);
    end
    chk("bounce_no_press", n_press, p0);

    // Release bounce, hold across bounce, then clean release
    btn_n = 1'b0; ticks(12);
    r0 = n_rel;
    btn_n = 1'b1; ticks(2);
    btn_n = 1'b0; ticks(25);
    chk("rel_bounce_no_rel", n_rel, r0);
    chk("hold_kept", hold_flag, 1'b1);
    btn_n = 1'b1; ticks(10);
    chk("hold_cleared", hold_flag, 1'b0);

    // Reset while in RELEASE_WAIT with hold_flag set
    btn_n = 1'b0; ticks(25);
    btn_n = 1'b1; ticks(3);
    chk("pre_reset_hold", hold_flag, 1'b1);
    chk("pre_reset_clean", btn_clean_n, 1'b0);
    btn_n = 1'b0;
    r0 = n_rel;
    p0 = n_press;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); @(posedge clk);
    #1 chk_reset_outputs("heldreset");
    #1 rst = 1'b1;
    model_reset();
    ticks(12);
    chk("reset_no_release", n_rel, r0);
    chk("reset_fresh_press", n_press, p0 + 1);
    btn_n = 1'b1; ticks(10);

    // Event counter chain: 15 clean presses
    ev_cnt = 4'd0;
    p0 = n_press; r0 = n_rel;
    for (int k = 0; k < 15; k++) begin
      btn_n = 1'b0; ticks(9);
      btn_n = 1'b1; ticks(9);
    end
    chk("chain_press", n_press - p0, 15);
    chk("chain_release", n_rel - r0, 15);
    chk("chain_counter", ev_cnt, 4'hF);

    // Random bounce and hold segments
    for (int seg = 0; seg < 150; seg++) begin
      btn_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ticks($urandom_range(15, 35));
      else ticks($urandom_range(1, 7));
    end
    btn_n = 1'b1; ticks(10);
    chk("final_released", btn_clean_n, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
